// File: rtl/accum_stage_if.sv
// Handshake bundle for accum_stage: operand stream in, result out.
// master: operand source + result consumer (drives start/target/in_*/out_ready).
// slave:  accum_stage itself (drives in_ready, out_valid, acc, carry_cnt, ovf, busy).
interface accum_stage_if #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] target;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] carry_cnt;
    logic             ovf;
    logic             busy;

    modport master (
        output start, target, in_valid, in_data, out_ready,
        input  in_ready, out_valid, acc, carry_cnt, ovf, busy
    );

    modport slave (
        input  start, target, in_valid, in_data, out_ready,
        output in_ready, out_valid, acc, carry_cnt, ovf, busy
    );
endinterface

// File: rtl/accum_stage.sv
// Purpose: accumulates `target` 6-bit operands into a 6-bit sum plus carry count.
// Latency: result valid 1 edge after the last operand transfer (0 operands: 1 edge after start).
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (accum_stage_if.slave).
module accum_stage #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    accum_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] carry_q;
    logic             ovf_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] op_cnt;

    logic [WIDTH:0]   sum;
    logic             xfer;
    logic [CNT_W-1:0] op_cnt_nxt;

    always_comb begin
        // Same arithmetic as the upstream adder: zero carry-in, MSB is carry-out.
        sum        = {1'b0, acc_q} + {1'b0, bus.in_data};
        xfer       = (state == ACCUM) && bus.in_valid;
        op_cnt_nxt = op_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc_q    <= '0;
            carry_q  <= '0;
            ovf_q    <= 1'b0;
            target_q <= '0;
            op_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc_q    <= '0;
                        carry_q  <= '0;
                        ovf_q    <= 1'b0;
                        op_cnt   <= '0;
                        target_q <= bus.target;
                        state    <= (bus.target == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_q   <= sum[WIDTH-1:0];
                        carry_q <= carry_q + CNT_W'(sum[WIDTH]);
                        ovf_q   <= ovf_q | sum[WIDTH];
                        op_cnt  <= op_cnt_nxt;
                        if (op_cnt_nxt == target_q) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; out_ready wins.
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are pure state decodes, so nothing from the input
    // side reaches an output combinationally.
    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.acc       = acc_q;
    assign bus.carry_cnt = carry_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/accum_stage.md
# accum_stage

Sequential accumulator stage downstream of the 6-bit ripple-carry adder. It accepts a stream of 6-bit operands over a valid/ready handshake and adds each one to a running total using the same arithmetic as the adder stage: 6-bit + 6-bit, carry-in 0, 7-bit result. It counts carry-outs so the true total is recoverable, then presents the result over a second valid/ready handshake. It sits between the operand source and the ALU result consumer.

## Interface
- WIDTH, 6, operand and accumulator width (matches adder stage)
- CNT_W, 4, width of operand-count target and carry counter
- clk  input  1  rising-edge clock; the block's only clock
- rst_n  input  1  reset; asynchronous, active-low; the block's only reset
- start  input  1  one-cycle request to begin a new accumulation (honoured in IDLE only)
- target  input  CNT_W  number of operands to accumulate, sampled when start is honoured
- in_valid  input  1  operand available
- in_data  input  WIDTH  operand
- in_ready  output  1  block accepts operand this cycle
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result this cycle
- acc  output  WIDTH  running/final sum modulo 2^WIDTH
- carry_cnt  output  CNT_W  number of carry-outs produced; true sum = carry_cnt*2^WIDTH + acc
- ovf  output  1  sticky; set by any carry-out during the current accumulation
- busy  output  1  high in ACCUM and DONE

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - When start=1: clear acc, carry_cnt, ovf and the operand counter; latch target.
  - Go to ACCUM if target!=0; go to DONE if target==0.
- ACCUM:
  - in_ready=1.
  - Transfer when in_valid & in_ready. On that edge: {c,acc} <= acc + in_data (7-bit result); carry_cnt <= carry_cnt + c; ovf <= ovf | c; operand counter increments.
  - On the transfer whose counter value reaches the latched target: go to DONE.
  - in_valid=0 leaves all state unchanged.
- DONE:
  - in_ready=0, out_valid=1; acc, carry_cnt and ovf are held stable.
  - When out_valid & out_ready: go to IDLE. Outputs keep their final values until the next honoured start.
- start is ignored in ACCUM and DONE.
- carry_cnt wraps modulo 2^CNT_W. This cannot occur, because carries ≤ target ≤ 2^CNT_W-1.
- Reset (asynchronous, any state, including mid-accumulation):
  - State goes to IDLE.
  - acc=0, carry_cnt=0, ovf=0, in_ready=0, out_valid=0, busy=0; target and operand counter cleared.
  - Effective immediately on rst_n falling edge; no partial result is kept.
- After rst_n rises, the first edge may honour start.

## Timing
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid, in_data or out_ready to any output.
- start honoured at edge k -> busy=1 and in_ready=1 from k (ACCUM). With target==0, out_valid=1 from k instead.
- Operand accepted at edge k -> updated acc/carry_cnt/ovf visible after k.
- Maximum throughput: one operand per cycle.
- Last operand accepted at edge k -> out_valid=1 and in_ready=0 after k. Latency: 1 edge from final transfer to valid result.
- Result consumed at edge k -> out_valid=0 and busy=0 after k. The earliest next start is honoured at edge k+1.
- out_ready=0 in DONE holds out_valid=1 and the result indefinitely.
- Simultaneous start and out_ready in DONE: out_ready is acted on and start is dropped.

## Test plan
- Reset, start target=3, operands 10, 20, 30 back-to-back -> out_valid 1 edge after third transfer; acc=60, carry_cnt=0, ovf=0.
- target=2, operands 63 then 1 -> acc=0, carry_cnt=1, ovf=1. Follow with a new start, target=1, operand 5 -> acc=5, ovf=0 (sticky flag cleared by the new start).
- target=15, all operands 63, with in_valid deasserted every other cycle -> exactly 15 transfers, in_ready drops after the 15th; acc=49, carry_cnt=14 (14*64+49=945).
- target=0 -> out_valid=1 the edge after start; acc=0, carry_cnt=0; no in_ready pulse.
- DONE with out_ready=0 for 5 cycles, start pulsed during that time -> result stable, start ignored. out_ready=1 -> IDLE next edge.
- rst_n driven low mid-ACCUM after 2 of 4 operands (asynchronously, between edges) -> all outputs 0 immediately. After release, a fresh target=1 accumulation with operand 7 gives acc=7.
